// File: rtl/xor_stream_parity_pkg.sv
// Shared definitions for the streaming XOR column-parity block and the checksum stage
// that consumes its result.
package xor_stream_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_WORDS = 16;

  function automatic int cwOf(input int maxWords);
    return $clog2(maxWords + 1);
  endfunction

  localparam int DEF_CW = cwOf(DEF_MAX_WORDS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Result layout at the default configuration, as seen by the checksum stage.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] column;
    logic                 parity;
    logic [DEF_CW-1:0]    count;
    logic                 overflow;
  } result_t;

endpackage

// File: rtl/xor_reduce.sv
// Combinational XOR reduction of a WIDTH-bit word to a single parity bit.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/xor_stream_parity.sv
// Folds every beat of a packet into a column-parity word with beat count, overflow flag
// and even/odd parity bit, delivered through a single registered valid/ready slot.
module xor_stream_parity
  import xor_stream_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  MAX_WORDS = DEF_MAX_WORDS,
  localparam int CW        = cwOf(MAX_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             i_ready,
  input  logic             odd_mode,
  output logic [WIDTH-1:0] o_column,
  output logic             o_parity,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_valid,
  input  logic             o_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] column;
    logic             parity;
    logic [CW-1:0]    count;
    logic             overflow;
  } slot_t;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  slot_t            slot_q, slot_d;

  logic             accept;
  logic             lastAccept;
  logic             cntAtMax;
  logic [WIDTH-1:0] accFold;
  logic [CW-1:0]    cntSat;
  logic             ovfNext;
  logic             foldParity;

  // Ready depends only on the slot and the downstream ready, never on i_valid.
  assign i_ready    = !o_valid || o_ready;
  assign accept     = i_valid && i_ready;
  assign lastAccept = accept && i_last;

  assign cntAtMax = (cnt_q == CW'(MAX_WORDS));
  assign accFold  = acc_q ^ i_data;
  assign cntSat   = cntAtMax ? cnt_q : cnt_q + CW'(1);
  assign ovfNext  = ovf_q | cntAtMax;

  xor_reduce #(
    .WIDTH(WIDTH)
  ) uReduce (
    .data_i  (accFold),
    .parity_o(foldParity)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (lastAccept) state_d = FULL;
      FULL:  if (!lastAccept && o_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (state_q == FULL);
  end

  // A last beat closes the packet into the slot and restarts the accumulator from zero.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    slot_d = slot_q;
    if (lastAccept) begin
      slot_d.column   = accFold;
      slot_d.parity   = foldParity ^ odd_mode;
      slot_d.count    = cntSat;
      slot_d.overflow = ovfNext;
      acc_d           = '0;
      cnt_d           = '0;
      ovf_d           = 1'b0;
    end else if (accept) begin
      acc_d = accFold;
      cnt_d = cntSat;
      ovf_d = ovfNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      slot_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      slot_q <= slot_d;
    end
  end

  assign o_column   = slot_q.column;
  assign o_parity   = slot_q.parity;
  assign o_count    = slot_q.count;
  assign o_overflow = slot_q.overflow;

endmodule

// File: tb/tb_xor_stream_parity.sv
// Directed bench for xor_stream_parity: hand-computed packet results, slot back-pressure,
// count saturation, mid-packet reset and back-to-back single-beat packets.
module tb_xor_stream_parity;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 16;
  localparam int CW        = 5;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] iData;
  logic             iValid;
  logic             iLast;
  logic             iReady;
  logic             oddMode;
  logic [WIDTH-1:0] oColumn;
  logic             oParity;
  logic [CW-1:0]    oCount;
  logic             oOverflow;
  logic             oValid;
  logic             oReady;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic [7:0] expColumn;
    logic       expParity;
  } vector_t;

  vector_t vectors[7];

  xor_stream_parity #(
    .WIDTH    (WIDTH),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_data    (iData),
    .i_valid   (iValid),
    .i_last    (iLast),
    .i_ready   (iReady),
    .odd_mode  (oddMode),
    .o_column  (oColumn),
    .o_parity  (oParity),
    .o_count   (oCount),
    .o_overflow(oOverflow),
    .o_valid   (oValid),
    .o_ready   (oReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic odd, input logic ordy);
    iValid  = v;
    iData   = d;
    iLast   = l;
    oddMode = odd;
    oReady  = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResult(input string name, input logic [7:0] col, input logic par,
                             input logic [4:0] cnt, input logic ovf);
    checkOutput({name, ".valid"}, oValid, 1'b1);
    checkOutput({name, ".column"}, oColumn, col);
    checkOutput({name, ".parity"}, oParity, par);
    checkOutput({name, ".count"}, oCount, cnt);
    checkOutput({name, ".overflow"}, oOverflow, ovf);
  endtask

  initial begin
    vectors[0] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vectors[1] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vectors[2] = '{8'h80, 1'b0, 8'h80, 1'b1};
    vectors[3] = '{8'h7F, 1'b0, 8'h7F, 1'b1};
    vectors[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    vectors[5] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
    vectors[6] = '{8'h01, 1'b1, 8'h01, 1'b0};

    // Reset held two cycles.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset.valid", oValid, 1'b0);
    checkOutput("reset.column", oColumn, 8'h00);
    checkOutput("reset.count", oCount, 5'd0);
    checkOutput("reset.parity", oParity, 1'b0);
    checkOutput("reset.overflow", oOverflow, 1'b0);
    checkOutput("reset.iready", iReady, 1'b1);

    // Three-beat packet.
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("pkt3.midvalid", oValid, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkResult("pkt3", 8'hC3, 1'b0, 5'd3, 1'b0);
    tick();
    checkOutput("pkt3.drained", oValid, 1'b0);

    // Single beat, odd parity.
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    checkResult("single", 8'h01, 1'b0, 5'd1, 1'b0);

    // Back-pressure: result held while a new beat waits.
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.iready", iReady, 1'b0);
      checkResult("hold", 8'h01, 1'b0, 5'd1, 1'b0);
      tick();
    end
    oReady = 1'b1;
    #1;
    checkOutput("release.iready", iReady, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkResult("release", 8'hAA, 1'b0, 5'd1, 1'b0);
    tick();
    checkOutput("release.drained", oValid, 1'b0);

    // Exactly MAX_WORDS beats: count hits the limit without overflow.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'h03, (i == 15), 1'b1, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkResult("exact16", 8'h00, 1'b1, 5'd16, 1'b0);

    // 18 beats: saturated count and sticky overflow.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 8'h01, (i == 17), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkResult("sat18", 8'h00, 1'b0, 5'd16, 1'b1);

    // Ignored i_last without i_valid.
    tick();
    applyStimulus(1'b0, 8'h77, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("lastnovalid.valid", oValid, 1'b0);

    // Partial packet discarded by a reset pulse.
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset.valid", oValid, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tick();
    checkResult("midreset", 8'h11, 1'b0, 5'd1, 1'b0);

    // Back-to-back single-beat packets, one result per cycle.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vectors[i].data, 1'b1, vectors[i].odd, 1'b1);
      tick();
      checkResult($sformatf("b2b%0d", i), vectors[i].expColumn, vectors[i].expParity,
                  5'd1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("b2b.drained", oValid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
